// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: collects DATA_W LSB-first data bits plus one
// parity bit, reports the assembled word, a parity error flag and a saturating error count.
module parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    input  logic              x_valid,
    input  logic              clr_cnt,
    output logic              z,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              par_err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int            BW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST    = BW'(DATA_W - 1);
    localparam logic          ODD_BIT = (ODD != 0);

    typedef enum logic {
        DATA,
        PARITY
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [BW-1:0]       bit_cnt;
    logic [DATA_W-1:0]   sreg;
    logic                exp_par;
    logic                par_bad;
    logic                par_take;

    assign exp_par  = z ^ ODD_BIT;
    assign par_take = x_valid && (state == PARITY);
    assign par_bad  = par_take && (x != exp_par);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DATA;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (x_valid) begin
            case (state)
                DATA:    if (bit_cnt == LAST) state_nx = PARITY;
                PARITY:  state_nx = DATA;
                default: state_nx = DATA;
            endcase
        end
    end

    // Datapath: bits and parity are only consumed on x_valid; frame_done is a
    // single-cycle pulse raised by the edge that consumes the parity bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            sreg       <= '0;
            z          <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (x_valid) begin
                case (state)
                    DATA: begin
                        sreg[bit_cnt] <= x;
                        z             <= z ^ x;
                        bit_cnt       <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        data_out   <= sreg;
                        par_err    <= (x != exp_par);
                        z          <= 1'b0;
                        frame_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Clear wins over a coincident error increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            err_cnt <= '0;
        end else if (par_bad && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: even/8-bit, even/2-bit-counter and
// odd-mode instances share one serial stimulus stream.
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       z_a, fd_a, pe_a;
    logic [7:0] do_a, ec_a;
    logic       z_s, fd_s, pe_s;
    logic [7:0] do_s;
    logic [1:0] ec_s;
    logic       z_o, fd_o, pe_o;
    logic [7:0] do_o, ec_o;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(8), .ODD(0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
        .z(z_a), .data_out(do_a), .frame_done(fd_a), .par_err(pe_a), .err_cnt(ec_a)
    );

    parity_frame_checker #(.DATA_W(8), .ODD(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
        .z(z_s), .data_out(do_s), .frame_done(fd_s), .par_err(pe_s), .err_cnt(ec_s)
    );

    parity_frame_checker #(.DATA_W(8), .ODD(1), .CNT_W(8)) dut_odd (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
        .z(z_o), .data_out(do_o), .frame_done(fd_o), .par_err(pe_o), .err_cnt(ec_o)
    );

    // Inputs change on the falling edge, so every call returns half a cycle
    // after the rising edge that consumed them, which is when outputs are read.
    task automatic drive(input logic b, input logic v);
        x       = b;
        x_valid = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) drive(1'($urandom), 1'($urandom));
        rst = 1'b0;
        n_cmp++; if (z_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_z: got %b want 0", z_a); end
        n_cmp++; if (do_a !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 00", do_a); end
        n_cmp++; if (fd_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", fd_a); end
        n_cmp++; if (pe_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_perr: got %b want 0", pe_a); end
        n_cmp++; if (ec_a !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", ec_a); end
        n_cmp++; if (ec_s !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_cnt_sat: got %0d want 0", ec_s); end
    endtask

    task automatic test_good_frame();
        logic [7:0] w;
        logic       zx;
        w  = 8'hA5;
        zx = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(w[i], 1'b1);
            zx = zx ^ w[i];
            n_cmp++; if (z_a !== zx) begin n_fail++; $display("[TB] FAIL good_z bit%0d: got %b want %b", i, z_a, zx); end
            n_cmp++; if (fd_a !== 1'b0) begin n_fail++; $display("[TB] FAIL good_early_done bit%0d: got %b want 0", i, fd_a); end
        end
        n_cmp++; if (z_a !== 1'b0) begin n_fail++; $display("[TB] FAIL good_z_final: got %b want 0", z_a); end
        drive(1'b0, 1'b1);
        n_cmp++; if (fd_a !== 1'b1) begin n_fail++; $display("[TB] FAIL good_done: got %b want 1", fd_a); end
        n_cmp++; if (do_a !== 8'hA5) begin n_fail++; $display("[TB] FAIL good_data: got %h want a5", do_a); end
        n_cmp++; if (pe_a !== 1'b0) begin n_fail++; $display("[TB] FAIL good_perr: got %b want 0", pe_a); end
        n_cmp++; if (ec_a !== 8'd0) begin n_fail++; $display("[TB] FAIL good_cnt: got %0d want 0", ec_a); end
        n_cmp++; if (z_a !== 1'b0) begin n_fail++; $display("[TB] FAIL good_z_clr: got %b want 0", z_a); end
        drive(1'b0, 1'b0);
        n_cmp++; if (fd_a !== 1'b0) begin n_fail++; $display("[TB] FAIL good_done_pulse: got %b want 0", fd_a); end
        n_cmp++; if (do_a !== 8'hA5) begin n_fail++; $display("[TB] FAIL good_data_hold: got %h want a5", do_a); end
    endtask

    task automatic test_bad_then_gaps();
        logic [7:0] w;
        logic       zx;
        do_reset();
        w = 8'h07;
        for (int i = 0; i < 8; i++) drive(w[i], 1'b1);
        drive(1'b0, 1'b1);
        n_cmp++; if (fd_a !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_done: got %b want 1", fd_a); end
        n_cmp++; if (pe_a !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_perr: got %b want 1", pe_a); end
        n_cmp++; if (ec_a !== 8'd1) begin n_fail++; $display("[TB] FAIL bad_cnt: got %0d want 1", ec_a); end
        n_cmp++; if (do_a !== 8'h07) begin n_fail++; $display("[TB] FAIL bad_data: got %h want 07", do_a); end
        w  = 8'hA5;
        zx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(w[i], 1'b1);
            zx = zx ^ w[i];
            for (int g = 0; g < 1 + (i % 3); g++) begin
                drive(1'b1, 1'b0);
                n_cmp++; if (z_a !== zx) begin n_fail++; $display("[TB] FAIL gap_z_hold bit%0d: got %b want %b", i, z_a, zx); end
                n_cmp++; if (fd_a !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_early_done bit%0d: got %b want 0", i, fd_a); end
            end
        end
        n_cmp++; if (pe_a !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_perr_hold: got %b want 1", pe_a); end
        n_cmp++; if (do_a !== 8'h07) begin n_fail++; $display("[TB] FAIL gap_data_hold: got %h want 07", do_a); end
        drive(1'b0, 1'b1);
        n_cmp++; if (fd_a !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_done: got %b want 1", fd_a); end
        n_cmp++; if (do_a !== 8'hA5) begin n_fail++; $display("[TB] FAIL gap_data: got %h want a5", do_a); end
        n_cmp++; if (pe_a !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_perr: got %b want 0", pe_a); end
        n_cmp++; if (ec_a !== 8'd1) begin n_fail++; $display("[TB] FAIL gap_cnt: got %0d want 1", ec_a); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
        rst     = 1'b1;
        clr_cnt = 1'b1;
        drive(1'b1, 1'b1);
        rst     = 1'b0;
        clr_cnt = 1'b0;
        n_cmp++; if (z_a !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_z: got %b want 0", z_a); end
        n_cmp++; if (ec_a !== 8'd0) begin n_fail++; $display("[TB] FAIL mid_rst_cnt: got %0d want 0", ec_a); end
        n_cmp++; if (do_a !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_rst_data: got %h want 00", do_a); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1);
            n_cmp++; if (fd_a !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_early_done bit%0d: got %b want 0", i, fd_a); end
        end
        drive(1'b0, 1'b1);
        n_cmp++; if (fd_a !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_done: got %b want 1", fd_a); end
        n_cmp++; if (do_a !== 8'hFF) begin n_fail++; $display("[TB] FAIL mid_data: got %h want ff", do_a); end
        n_cmp++; if (pe_a !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_perr: got %b want 0", pe_a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        logic [1:0] exp_s;
        w = 8'h07;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 8; i++) drive(w[i], 1'b1);
            drive(1'b0, 1'b1);
            exp_s = (k >= 3) ? 2'd3 : 2'(k);
            n_cmp++; if (fd_s !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done f%0d: got %b want 1", k, fd_s); end
            n_cmp++; if (ec_s !== exp_s) begin n_fail++; $display("[TB] FAIL b2b_sat_cnt f%0d: got %0d want %0d", k, ec_s, exp_s); end
            n_cmp++; if (ec_a !== 8'(k)) begin n_fail++; $display("[TB] FAIL b2b_cnt f%0d: got %0d want %0d", k, ec_a, k); end
        end
        for (int i = 0; i < 8; i++) drive(w[i], 1'b1);
        clr_cnt = 1'b1;
        drive(1'b0, 1'b1);
        clr_cnt = 1'b0;
        n_cmp++; if (ec_s !== 2'd0) begin n_fail++; $display("[TB] FAIL clr_prio_sat: got %0d want 0", ec_s); end
        n_cmp++; if (ec_a !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_prio: got %0d want 0", ec_a); end
        n_cmp++; if (pe_s !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_perr: got %b want 1", pe_s); end
        drive(1'b0, 1'b0);
        n_cmp++; if (ec_s !== 2'd0) begin n_fail++; $display("[TB] FAIL clr_hold: got %0d want 0", ec_s); end
    endtask

    task automatic test_odd_mode();
        logic [7:0] w;
        w = 8'hA5;
        do_reset();
        for (int i = 0; i < 8; i++) drive(w[i], 1'b1);
        drive(1'b1, 1'b1);
        n_cmp++; if (pe_o !== 1'b0) begin n_fail++; $display("[TB] FAIL odd_good_perr: got %b want 0", pe_o); end
        n_cmp++; if (ec_o !== 8'd0) begin n_fail++; $display("[TB] FAIL odd_good_cnt: got %0d want 0", ec_o); end
        n_cmp++; if (do_o !== 8'hA5) begin n_fail++; $display("[TB] FAIL odd_data: got %h want a5", do_o); end
        n_cmp++; if (pe_a !== 1'b1) begin n_fail++; $display("[TB] FAIL even_sees_odd_perr: got %b want 1", pe_a); end
        for (int i = 0; i < 8; i++) drive(w[i], 1'b1);
        drive(1'b0, 1'b1);
        n_cmp++; if (fd_o !== 1'b1) begin n_fail++; $display("[TB] FAIL odd_done: got %b want 1", fd_o); end
        n_cmp++; if (pe_o !== 1'b1) begin n_fail++; $display("[TB] FAIL odd_bad_perr: got %b want 1", pe_o); end
        n_cmp++; if (ec_o !== 8'd1) begin n_fail++; $display("[TB] FAIL odd_bad_cnt: got %0d want 1", ec_o); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_then_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        test_odd_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal range 1..32).
REQ-002 SHALL have parameter ODD, default 0, parity mode (0 = even, 1 = odd).
REQ-003 SHALL have parameter CNT_W, default 8, error counter width (legal range 1..16).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port x, input, 1 bit: serial bit, LSB-first data bits followed by one parity bit.
REQ-007 SHALL have port x_valid, input, 1 bit: qualifies x; a bit is consumed only on a cycle with x_valid=1.
REQ-008 SHALL have port clr_cnt, input, 1 bit: synchronous clear of err_cnt.
REQ-009 SHALL have port z, output, 1 bit: running XOR of the data bits consumed so far in the current frame.
REQ-010 SHALL have port data_out, output, DATA_W bits: last completed frame's data word.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse per completed frame.
REQ-012 SHALL have port par_err, output, 1 bit: parity result of the last completed frame.
REQ-013 SHALL have port err_cnt, output, CNT_W bits: saturating count of frames with a parity error.

Function
REQ-014 SHALL implement a 2-state FSM: DATA (collecting data bits) and PARITY (awaiting the parity bit).
REQ-015 In DATA with x_valid=1, SHALL shift x into bit position bit_cnt of an internal shift register, update z <= z ^ x, and increment bit_cnt.
REQ-016 In DATA, the consumed bit with bit_cnt = DATA_W-1 SHALL move the FSM to PARITY; bit_cnt SHALL reset to 0.
REQ-017 In PARITY with x_valid=1, SHALL compute expected parity = z ^ ODD and set par_err <= (x != expected).
REQ-018 In the same PARITY cycle, SHALL load data_out with the assembled word, clear z to 0, and return to DATA.
REQ-019 frame_done SHALL be 1 exactly in the cycle after the parity bit is consumed, and 0 otherwise.
REQ-020 Back-to-back frames SHALL be supported with zero idle cycles.
REQ-021 With x_valid=0, SHALL hold FSM state, bit_cnt, z and the shift register unchanged.
REQ-022 data_out and par_err SHALL hold their values until the next frame completes.
REQ-023 err_cnt SHALL increment by 1 when a frame completes with par_err=1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-024 clr_cnt=1 SHALL set err_cnt to 0 on the next edge, taking priority over a simultaneous increment.
REQ-025 frame_done, par_err and err_cnt SHALL NOT be affected by partial frames.

Reset
REQ-026 rst=1 SHALL, at the next rising clk edge, force FSM=DATA, bit_cnt=0, z=0, shift register=0, data_out=0, frame_done=0, par_err=0, err_cnt=0.
REQ-027 rst SHALL take priority over x_valid and clr_cnt.
REQ-028 rst asserted mid-frame SHALL discard the partial frame; the next consumed bit SHALL be data bit 0.

Verification (DATA_W=8, ODD=0, CNT_W=8 unless stated)
REQ-029 Reset check: rst high for 2 cycles with random x/x_valid -> z=0, data_out=0x00, frame_done=0, par_err=0, err_cnt=0.
REQ-030 Good frame: bits of 0xA5 (1,0,1,0,0,1,0,1), then parity bit 0, x_valid=1 throughout -> z=0 after the 8th data bit; one cycle later frame_done=1, data_out=0xA5, par_err=0, err_cnt=0.
REQ-031 Bad frame then gaps: 0x07 with parity bit 0 -> par_err=1, err_cnt=1. Then 0xA5/parity 0 with x_valid low 1-3 cycles between bits -> frame_done only after the parity bit, data_out=0xA5, par_err=0, err_cnt=1.
REQ-032 Reset mid-frame: 5 bits of 0x00, rst for 1 cycle, then 0xFF with parity 0 -> data_out=0xFF, par_err=0, no frame_done before the parity bit.
REQ-033 Saturation and clear: CNT_W=2, 5 consecutive error frames back-to-back -> err_cnt=3 after the 3rd and all later frames. clr_cnt asserted in the same cycle as an error increment -> err_cnt=0.
REQ-034 Odd mode: ODD=1, 0xA5 with parity bit 1 -> par_err=0. Same frame with parity bit 0 -> par_err=1, err_cnt=1.
